// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer that time-shares one external 1-bit full-adder
// cell, LSB first, and reports sum, carry-out and signed overflow with a done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   res_sh;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   res_cat;

    // Result bits collected so far plus the bit the cell is producing this cycle;
    // on the last RUN edge this is the complete sum.
    assign res_cat = {fa_sum, res_sh};

    // busy is a registered copy of (state == RUN), so the cell inputs are forced
    // to 0 outside RUN without decoding the state here.
    assign fa_a   = busy & a_sh[0];
    assign fa_b   = busy & b_sh[0];
    assign fa_cin = busy & carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
                        a_sh    <= a;
                        b_sh    <= sub ? ~b : b;
                        carry_q <= sub;
                        res_sh  <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_cat[WIDTH-1:1];
                    carry_q <= fa_cout;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // carry_q here is the carry into the MSB.
                        sum   <= res_cat;
                        cout  <= fa_cout;
                        ovf   <= carry_q ^ fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with a behavioural full-adder cell
// and a result scoreboard filled at stimulus time and drained on done.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } exp_t;

    exp_t sb[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf)
    );

    // The shared full-adder cell.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   full;
        exp_t             e;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, s};
        e.s  = full[WIDTH-1:0];
        e.c  = full[WIDTH];
        e.v  = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard drain: every done pulse must match the oldest pending operation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            vectors++;
            if (busy === 1'b1 && done === 1'b1) begin
                miscompares++;
                $display("FAIL busy_done_overlap busy=%b done=%b required not both high", busy, done);
            end
            if (done === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done sum=%h with no pending operation", sum);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin
                        miscompares++;
                        $display("FAIL result sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e.s, e.c, e.v);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        sb.push_back(model(x, y, s));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; returns cycles elapsed since the caller's sample point
    // and leaves the bench one cycle later, back in IDLE.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout waited=%0d cycles required done within 20", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        start = 1'b1;
        sub   = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin} !== 15'b0) begin
                miscompares++;
                $display("FAIL reset_outputs busy=%b done=%b sum=%h cout=%b ovf=%b fa=%b%b%b required all 0",
                         busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin);
            end
        end
        rst_n = 1'b1;
        issue(8'h01, 8'h01, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_start busy=%b required 1", busy);
        end
        wait_done(n);
        vectors++;
        if (n != WIDTH) begin
            miscompares++;
            $display("FAIL reset_release_latency cycles=%0d required %0d", n, WIDTH);
        end
    endtask

    task automatic test_add_ovf;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] s0;
        logic [WIDTH-1:0] cin_exp;
        logic             c;
        x  = 8'h5A;
        y  = 8'h3C;
        s0 = sum;
        c  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cin_exp[i] = c;
            c = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        issue(x, y, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            vectors++;
            if ({busy, done, fa_a, fa_b, fa_cin, sum} !== {1'b1, 1'b0, x[i], y[i], cin_exp[i], s0}) begin
                miscompares++;
                $display("FAIL add_run_bit%0d busy=%b done=%b fa=%b%b%b sum=%h required busy=1 done=0 fa=%b%b%b sum=%h",
                         i, busy, done, fa_a, fa_b, fa_cin, sum, x[i], y[i], cin_exp[i], s0);
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({done, busy, fa_a, fa_b, fa_cin} !== 5'b10000) begin
            miscompares++;
            $display("FAIL add_done_cycle done=%b busy=%b fa=%b%b%b required done=1 busy=0 fa=000",
                     done, busy, fa_a, fa_b, fa_cin);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({done, busy, sum, cout, ovf} !== {2'b00, 8'h96, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL add_hold done=%b busy=%b sum=%h cout=%b ovf=%b required done=0 busy=0 sum=96 cout=0 ovf=1",
                     done, busy, sum, cout, ovf);
        end
    endtask

    task automatic test_add_carry;
        int n;
        issue(8'hFF, 8'h01, 1'b0);
        wait_done(n);
        issue(8'h7F, 8'h00, 1'b0);
        wait_done(n);
    endtask

    task automatic test_sub;
        int n;
        issue(8'h10, 8'h20, 1'b1);
        wait_done(n);
        issue(8'h80, 8'h01, 1'b1);
        wait_done(n);
        issue(8'h33, 8'h33, 1'b1);
        wait_done(n);
    endtask

    task automatic test_ignored_start;
        int ndone;
        issue(8'h01, 8'h02, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        a     = 8'hAA;
        b     = 8'h55;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        vectors++;
        if (ndone != 1 || busy !== 1'b0 || sum !== 8'h03) begin
            miscompares++;
            $display("FAIL ignored_start dones=%0d busy=%b sum=%h required dones=1 busy=0 sum=03",
                     ndone, busy, sum);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] last_sum;
        int               nd;
        int               last_t;
        bit               stop;
        x        = 8'h11;
        y        = 8'h22;
        a        = x;
        b        = y;
        sub      = 1'b0;
        start    = 1'b1;
        sb.push_back(model(x, y, 1'b0));
        nd       = 0;
        last_t   = 0;
        last_sum = '0;
        stop     = 1'b0;
        for (int cyc = 1; cyc <= 40 && !stop; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                nd++;
                if (nd > 1) begin
                    vectors++;
                    if (cyc - last_t != WIDTH + 2) begin
                        miscompares++;
                        $display("FAIL b2b_period cycles=%0d required %0d", cyc - last_t, WIDTH + 2);
                    end
                end
                last_t   = cyc;
                last_sum = sum;
                if (nd < 3) begin
                    x   = x + 8'h37;
                    y   = y ^ 8'h5C;
                    sub = ~sub;
                    a   = x;
                    b   = y;
                    sb.push_back(model(x, y, sub));
                end else begin
                    start = 1'b0;
                    stop  = 1'b1;
                end
            end else if (nd > 0) begin
                vectors++;
                if (sum !== last_sum) begin
                    miscompares++;
                    $display("FAIL b2b_sum_stable sum=%h required %h", sum, last_sum);
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (nd != 3) begin
            miscompares++;
            $display("FAIL b2b_done_count dones=%0d required 3", nd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int n;
        issue(8'hF0, 8'h0F, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin} !== 15'b0) begin
            miscompares++;
            $display("FAIL reset_mid_async busy=%b done=%b sum=%h cout=%b ovf=%b fa=%b%b%b required all 0",
                     busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, sum} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_mid_hold busy=%b done=%b sum=%h required 0", busy, done, sum);
        end
        rst_n = 1'b1;
        issue(8'h03, 8'h04, 1'b0);
        wait_done(n);
        vectors++;
        if (n != WIDTH || sum !== 8'h07) begin
            miscompares++;
            $display("FAIL reset_mid_restart cycles=%0d sum=%h required cycles=%0d sum=07", n, sum, WIDTH);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        test_reset;
        test_add_ovf;
        test_add_carry;
        test_sub;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL pending_results outstanding=%0d required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
